gray_code_counter: RTL and testbench

- Parametrised up/down counter that holds its state in binary and presents both binary and Gray-coded outputs. Both outputs are registered and update on the same clock edge.
- Supports a parallel load from a Gray-coded value. The load value is decoded to binary internally.
- Successor to the team's fixed 4-bit combinational binary-to-Gray converter. Intended for clock-domain-crossing pointers and position encoders.

---
 rtl/gray_code_counter.sv | 73 +++++++
 tb/tb_gray_code_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - up/down counter with registered binary and Gray outputs plus Gray-coded load
// Build option GRAY_CNT_SAT_EN: hold at the terminal count instead of wrapping.
module gray_code_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             term
);

  localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] MAX_CNT  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] gray_q;
  logic             term_q;
  logic [WIDTH-1:0] nxt;
  logic             term_nxt;
  logic             at_term;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    nxt      = cnt;
    term_nxt = 1'b0;
    at_term  = up_dn ? (cnt == MAX_CNT) : (cnt == '0);
    if (load) begin
      nxt = gray2bin(load_gray);
    end else if (en) begin
      term_nxt = at_term;
`ifdef GRAY_CNT_SAT_EN
      if (!at_term) begin
        nxt = up_dn ? cnt + 1'b1 : cnt - 1'b1;
      end
`else
      nxt = up_dn ? cnt + 1'b1 : cnt - 1'b1;
`endif
    end
  end

  // Gray output is registered from nxt, so it tracks cnt on the same edge without extra latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= RST_BIN;
      gray_q <= RST_GRAY;
      term_q <= 1'b0;
    end else begin
      cnt    <= nxt;
      gray_q <= nxt ^ (nxt >> 1);
      term_q <= term_nxt;
    end
  end

  assign bin_out  = cnt;
  assign gray_out = gray_q;
  assign term     = term_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - self-checking bench for gray_code_counter
module tb_gray_code_counter;

`ifdef GRAY_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_n  = 0;
  int fail_n = 0;

  // WIDTH 4, RESET_VAL 0
  logic       rst4, en4, up4, ld4, t4;
  logic [3:0] lg4, b4, g4;
  // WIDTH 4, RESET_VAL 5
  logic       rst5, en5, up5, ld5, t5;
  logic [3:0] lg5, b5, g5;
  // WIDTH 8, RESET_VAL 0
  logic       rst8, en8, up8, ld8, t8;
  logic [7:0] lg8, b8, g8;

  gray_code_counter #(.WIDTH(4), .RESET_VAL(0)) u4 (
    .clk(clk), .rst(rst4), .en(en4), .up_dn(up4), .load(ld4), .load_gray(lg4),
    .bin_out(b4), .gray_out(g4), .term(t4));
  gray_code_counter #(.WIDTH(4), .RESET_VAL(5)) u5 (
    .clk(clk), .rst(rst5), .en(en5), .up_dn(up5), .load(ld5), .load_gray(lg5),
    .bin_out(b5), .gray_out(g5), .term(t5));
  gray_code_counter #(.WIDTH(8), .RESET_VAL(0)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .up_dn(up8), .load(ld8), .load_gray(lg8),
    .bin_out(b8), .gray_out(g8), .term(t8));

  typedef struct packed {
    bit       load;
    bit       en;
    bit       up;
    bit [3:0] lg;
    bit [3:0] bin;
    bit [3:0] gray;
    bit       term;
  } vec_t;

  vec_t vecs[$];
  bit [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                          4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (!ok) begin
      fail_n++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act === exp, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gray decode by exhaustive search for the code word: independent of any bit-serial formula.
  function automatic int ref_g2b(input int g, input int w);
    for (int v = 0; v < (1 << w); v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  initial begin
    int   m_bin;
    bit   m_term;
    logic [7:0] prev8;
    logic [3:0] prev4;

    rst4 = 1; en4 = 0; up4 = 0; ld4 = 0; lg4 = 0;
    rst5 = 1; en5 = 0; up5 = 0; ld5 = 0; lg5 = 0;
    rst8 = 1; en8 = 0; up8 = 0; ld8 = 0; lg8 = 0;

    for (int i = 1; i < 16; i++) vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h0, 4'(i), gseq[i], 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h0, SAT ? 4'hF : 4'h0, SAT ? 4'h8 : 4'h0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'h0, SAT ? 4'hF : 4'h0, SAT ? 4'h8 : 4'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hB, 4'hD, 4'hB, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'h0 : 4'hF, SAT ? 4'h0 : 4'h8, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'h0 : 4'hE, SAT ? 4'h0 : 4'h9, SAT});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'h0, SAT ? 4'h1 : 4'hF, SAT ? 4'h1 : 4'h8, 1'b0});

    #2;
    chk_eq("reset_bin", b4, 0);
    chk_eq("reset_gray", g4, 0);
    chk_eq("reset_term", t4, 0);
    chk_eq("reset5_bin", b5, 5);
    chk_eq("reset5_gray", g5, 7);
    @(posedge clk);
    #1;
    rst4 = 0; rst5 = 0; rst8 = 0;
    step();
    chk_eq("idle_bin", b4, 0);

    foreach (vecs[k]) begin
      prev4 = g4;
      ld4 = vecs[k].load; en4 = vecs[k].en; up4 = vecs[k].up; lg4 = vecs[k].lg;
      step();
      chk_eq($sformatf("vec%0d_bin", k), b4, vecs[k].bin);
      chk_eq($sformatf("vec%0d_gray", k), g4, vecs[k].gray);
      chk_eq($sformatf("vec%0d_term", k), t4, vecs[k].term);
      if (!vecs[k].load)
        check($sformatf("vec%0d_onebit", k), $countones(g4 ^ prev4) <= 1, $countones(g4 ^ prev4), 1);
    end
    en4 = 0; ld4 = 0;

    en5 = 1; up5 = 1;
    step();
    chk_eq("r5_step_bin", b5, 6);
    chk_eq("r5_step_gray", g5, 5);
    rst5 = 1;
    #1;
    chk_eq("r5_async_bin", b5, 5);
    chk_eq("r5_async_gray", g5, 7);
    chk_eq("r5_async_term", t5, 0);
    #1;
    rst5 = 0;
    step();
    chk_eq("r5_resume_bin", b5, 6);
    chk_eq("r5_resume_gray", g5, 5);
    en5 = 0;

    m_bin = 0;
    for (int c = 0; c < 10000; c++) begin
      prev8 = g8;
      ld8 = ($urandom_range(0, 7) == 0);
      en8 = ($urandom_range(0, 3) != 0);
      up8 = $urandom_range(0, 1);
      lg8 = 8'($urandom);
      // Bias toward the ends so terminal steps occur often.
      if (!ld8 && $urandom_range(0, 15) == 0) begin
        ld8 = 1;
        lg8 = $urandom_range(0, 1) ? 8'h80 : 8'h00;
      end
      m_term = 0;
      if (ld8) begin
        m_bin = ref_g2b(lg8, 8);
      end else if (en8) begin
        m_term = (up8 && m_bin == 255) || (!up8 && m_bin == 0);
        if (!(SAT && m_term)) m_bin = up8 ? (m_bin + 1) % 256 : (m_bin + 255) % 256;
      end
      step();
      chk_eq("rnd_bin", b8, 32'(m_bin));
      chk_eq("rnd_gray", g8, 32'(b8 ^ (b8 >> 1)));
      chk_eq("rnd_term", t8, 32'(m_term));
      if (!ld8)
        check("rnd_onebit", $countones(g8 ^ prev8) <= 1, $countones(g8 ^ prev8), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
